driver_keys_switches: RTL and testbench

//  Memory-mapped input peripheral: CPU read side of the board I/O (complements the 7-seg output driver).
//  - Samples slide switches SW[9:0] and push-buttons KEY[3:0] (physical, active-low).
//  - Synchronises and debounces both inputs, captures key-press events.
//  - Exposes state and events to the DLX core over the same chip-select/word-address bus as other drivers.

---
 rtl/driver_keys_switches.sv | 111 +++++++++++
 tb/tb_driver_keys_switches.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/driver_keys_switches.sv
// CPU-readable board inputs: synchronised, debounced slide switches and push-buttons
// with key-press event capture, press counter and level interrupt.
module driver_keys_switches #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned N_SW            = 10,
  parameter int unsigned N_KEY           = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_SW-1:0]   sw,
  input  logic [N_KEY-1:0]  key_n,
  input  logic              write_enable,
  input  logic              cs_keys,
  input  logic [31:0]       address,
  input  logic [31:0]       data_write,
  output logic [31:0]       data_read,
  output logic              irq
);

  localparam int unsigned N_IN = N_SW + N_KEY;
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  // Buttons idle high, so their synchroniser resets to released.
  localparam logic [N_IN-1:0] SyncRst = {{N_KEY{1'b1}}, {N_SW{1'b0}}};

  logic [N_IN-1:0]  sync1_q, sync2_q, in_sync;
  logic [N_IN-1:0]  stable_q, stable_d;
  logic [CntW-1:0]  cnt_q [N_IN];
  logic [CntW-1:0]  cnt_d [N_IN];
  logic [N_KEY-1:0] key_stable, key_rise;
  logic [N_KEY-1:0] edge_cap_q, edge_cap_d;
  logic [N_KEY-1:0] irq_mask_q, irq_mask_d;
  logic [15:0]      press_cnt_q, press_cnt_d;
  logic [31:0]      data_read_q, data_read_d, rd_data;
  logic [2:0]       addr;
  logic             wr, rd, rise_any;
  logic             unused_bits;

  assign unused_bits = ^{address[31:3], data_write[31:N_KEY]};

  assign in_sync    = {~sync2_q[N_IN-1:N_SW], sync2_q[N_SW-1:0]};
  assign key_stable = stable_q[N_IN-1:N_SW];
  assign key_rise   = stable_d[N_IN-1:N_SW] & ~key_stable;
  assign rise_any   = |key_rise;
  assign addr       = address[2:0];
  assign wr         = cs_keys & write_enable;
  assign rd         = cs_keys & ~write_enable;
  assign data_read  = data_read_q;
  assign irq        = |(edge_cap_q & irq_mask_q);

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (in_sync[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) stable_d[i] = in_sync[i];
        else                    cnt_d[i]    = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    edge_cap_d = edge_cap_q;
    if (wr && addr == 3'd2) edge_cap_d = edge_cap_q & ~data_write[N_KEY-1:0];
    // A rise on the clearing edge must not be lost.
    edge_cap_d = edge_cap_d | key_rise;

    irq_mask_d = irq_mask_q;
    if (wr && addr == 3'd3) irq_mask_d = data_write[N_KEY-1:0];

    press_cnt_d = press_cnt_q;
    if (wr && addr == 3'd4)                     press_cnt_d = rise_any ? 16'd1 : 16'd0;
    else if (rise_any && press_cnt_q != 16'hFFFF) press_cnt_d = press_cnt_q + 16'd1;
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      3'd0:    rd_data[N_SW-1:0]  = stable_q[N_SW-1:0];
      3'd1:    rd_data[N_KEY-1:0] = key_stable;
      3'd2:    rd_data[N_KEY-1:0] = edge_cap_q;
      3'd3:    rd_data[N_KEY-1:0] = irq_mask_q;
      3'd4:    rd_data[15:0]      = press_cnt_q;
      default: rd_data            = '0;
    endcase
    data_read_d = rd ? rd_data : data_read_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q     <= SyncRst;
      sync2_q     <= SyncRst;
      stable_q    <= '0;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
      edge_cap_q  <= '0;
      irq_mask_q  <= '0;
      press_cnt_q <= '0;
      data_read_q <= '0;
    end else begin
      sync1_q     <= {key_n, sw};
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
      edge_cap_q  <= edge_cap_d;
      irq_mask_q  <= irq_mask_d;
      press_cnt_q <= press_cnt_d;
      data_read_q <= data_read_d;
    end
  end

endmodule

// File: tb/tb_driver_keys_switches.sv
// Directed bench for driver_keys_switches with a short debounce window.
module tb_driver_keys_switches;

  logic        clk;
  logic        reset_n;
  logic [9:0]  sw;
  logic [3:0]  key_n;
  logic        write_enable;
  logic        cs_keys;
  logic [31:0] address;
  logic [31:0] data_write;
  logic [31:0] data_read;
  logic        irq;

  int n_checks = 0;
  int n_fails  = 0;

  driver_keys_switches #(
    .DEBOUNCE_CYCLES(4),
    .N_SW           (10),
    .N_KEY          (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sw          (sw),
    .key_n       (key_n),
    .write_enable(write_enable),
    .cs_keys     (cs_keys),
    .address     (address),
    .data_write  (data_write),
    .data_read   (data_read),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
    cs_keys      = 1'b1;
    write_enable = 1'b0;
    address      = {29'b0, a};
    @(posedge clk);
    #1 check(tag, data_read, exp);
    @(negedge clk);
    cs_keys = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    cs_keys      = 1'b1;
    write_enable = 1'b1;
    address      = {29'b0, a};
    data_write   = d;
    @(posedge clk);
    @(negedge clk);
    cs_keys      = 1'b0;
    write_enable = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n      = 1'b0;
    sw           = '0;
    key_n        = 4'hF;
    write_enable = 1'b0;
    cs_keys      = 1'b0;
    address      = '0;
    data_write   = '0;

    // 1. Reset, with button activity while reset is held
    wait_cyc(2);
    key_n = 4'h0;
    wait_cyc(3);
    key_n = 4'hF;
    wait_cyc(2);
    reset_n = 1'b1;
    check("rst_data_read", data_read, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    for (int a = 0; a < 5; a++) bus_read(3'(a), 32'h0, $sformatf("rst_reg%0d", a));
    wait_cyc(10);
    bus_read(3'd2, 32'h0, "rst_no_edge");
    bus_read(3'd4, 32'h0, "rst_no_press");

    // 2. Switch latency and glitch rejection
    sw = 10'h2A5;
    wait_cyc(5);
    bus_read(3'd0, 32'h0, "sw_before_cycle6");
    bus_read(3'd0, 32'h2A5, "sw_at_cycle6");
    sw = 10'h2A4;
    wait_cyc(3);
    sw = 10'h2A5;
    wait_cyc(10);
    bus_read(3'd0, 32'h2A5, "sw_glitch");

    // 3. Press key 2, mask, W1C
    key_n = 4'b1011;
    wait_cyc(10);
    bus_read(3'd1, 32'h4, "key_state");
    bus_read(3'd2, 32'h4, "key_edge");
    bus_read(3'd4, 32'h1, "press_cnt_1");
    check("irq_masked", {31'b0, irq}, 32'h0);
    bus_write(3'd3, 32'hFFFF_FFF4);
    bus_read(3'd3, 32'h4, "irq_mask_rd");
    check("irq_on", {31'b0, irq}, 32'h1);
    bus_write(3'd2, 32'h4);
    check("irq_off_w1c", {31'b0, irq}, 32'h0);
    bus_read(3'd2, 32'h0, "key_edge_w1c");
    key_n = 4'hF;
    wait_cyc(10);
    bus_read(3'd1, 32'h0, "key_released");
    bus_read(3'd4, 32'h1, "press_cnt_release");

    // 4. W1C on the same edge as the rise of key 1
    key_n = 4'b1101;
    wait_cyc(5);
    bus_write(3'd2, 32'h2);
    bus_read(3'd2, 32'h2, "edge_set_wins");
    bus_write(3'd2, 32'h2);
    bus_read(3'd2, 32'h0, "edge_clr_later");
    key_n = 4'hF;
    wait_cyc(10);

    // 5. Press counter: simultaneous rises, clear-on-rise, saturation
    key_n = 4'b0110;
    wait_cyc(10);
    bus_read(3'd4, 32'h3, "press_cnt_simul");
    bus_read(3'd2, 32'h9, "key_edge_simul");
    key_n = 4'hF;
    wait_cyc(10);
    key_n = 4'b1110;
    wait_cyc(5);
    bus_write(3'd4, 32'h0);
    bus_read(3'd4, 32'h1, "press_clr_on_rise");
    key_n = 4'hF;
    wait_cyc(10);
    force dut.press_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.press_cnt_q;
    bus_read(3'd4, 32'hFFFF, "press_preload");
    key_n = 4'b1011;
    wait_cyc(10);
    bus_read(3'd4, 32'hFFFF, "press_saturate");
    check("irq_key2_again", {31'b0, irq}, 32'h1);
    key_n = 4'hF;
    bus_write(3'd4, 32'h1234);
    bus_read(3'd4, 32'h0, "press_clear");

    // 6. Unmapped reads, RO write, chip-select hold
    bus_read(3'd0, 32'h2A5, "sw_prefill");
    bus_read(3'd5, 32'h0, "addr5");
    bus_read(3'd0, 32'h2A5, "sw_prefill2");
    bus_read(3'd7, 32'h0, "addr7");
    bus_write(3'd0, 32'hFFFF_FFFF);
    bus_read(3'd0, 32'h2A5, "sw_ro_write");
    address = 32'd2;
    @(posedge clk);
    #1 check("cs_low_hold", data_read, 32'h2A5);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
